decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of one-hot output lines; legal range is 2..256.
REQ-002 The block SHALL define SEL_W = $clog2(WIDTH) as a derived localparam, meaning the select-input width; it SHALL NOT be user-overridable.

Interface
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst; polarity and synchronicity are fixed.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in  input  SEL_W  binary select index.
REQ-007 enable  input  1  decode enable; 0 forces all outputs inactive.
REQ-008 out  output  WIDTH  registered one-hot decode result.
REQ-009 valid  output  1  registered flag: out holds a legal one-hot decode.
REQ-010 range_err  output  1  registered flag: enable=1 with in >= WIDTH (reachable only when WIDTH is not a power of two).

Function
REQ-011 All outputs SHALL be registered on the rising edge of clk, giving exactly 1 cycle of latency from sampled inputs to outputs.
REQ-012 The registers SHALL have no combinational input-to-output path.
REQ-013 When enable=1 and in < WIDTH at a clock edge, the block SHALL drive out[in]=1 and all other bits of out to 0, set valid=1, and set range_err=0.
REQ-014 When enable=0 at a clock edge, the block SHALL drive out=0, valid=0, and range_err=0, regardless of in.
REQ-015 When enable=1 and in >= WIDTH, the block SHALL drive out=0, valid=0, and range_err=1.
REQ-016 out SHALL always be either all-zero or exactly one-hot; more than one bit set is never permitted.
REQ-017 valid SHALL equal the OR-reduction of the registered out.
REQ-018 Outputs SHALL update every cycle with no hold behaviour; new inputs take effect at the next edge.
REQ-019 in or enable changing every cycle SHALL produce a matching output stream delayed by 1 cycle, with no dropped or merged values.
REQ-020 The boundary indices in=0 and in=WIDTH-1 SHALL decode to out[0] and out[WIDTH-1] respectively.
REQ-021 For power-of-two WIDTH, range_err SHALL be constant 0.
REQ-022 X or Z on in while enable=0 SHALL NOT propagate to any output.

Reset
REQ-023 When rst=1 at a rising edge of clk, the block SHALL set out=0, valid=0, and range_err=0.
REQ-024 Reset SHALL take priority over enable and in.
REQ-025 Reset asserted mid-stream SHALL clear the outputs at the same edge.
REQ-026 On the first edge with rst=0, the block SHALL decode the inputs present at that edge.
REQ-027 Before the first reset edge, output values are undefined; the bench SHALL apply reset for at least 1 cycle before checking.

Verification
REQ-028 Reset: WIDTH=8; rst=1 for 2 cycles with enable=1, in=5 -> out=0x00, valid=0, range_err=0 throughout; after rst deasserts, next edge -> out=0x20.
REQ-029 Disable: WIDTH=8; enable=0, in=3 -> out=0x00, valid=0; then enable=1, in=3 -> out=0x08, valid=1 one cycle later.
REQ-030 Boundaries: WIDTH=8; enable=1; in=7 -> out=0x80; then in=0 -> out=0x01; each result appears exactly 1 cycle after its input.
REQ-031 Sweep: WIDTH=8; enable=1; in=0..7 on consecutive cycles -> out = 1<<in delayed 1 cycle, exactly one bit set each cycle, valid=1 throughout.
REQ-032 Out-of-range: WIDTH=5; enable=1; in=4 -> out=0x10, range_err=0; then in=6 -> out=0x00, valid=0, range_err=1.
REQ-033 Mid-stream reset: WIDTH=8; during a sweep, assert rst for 1 cycle at in=4 -> out=0x00 at that edge; the sweep resumes with the correct decode at the following edge.

Source files
------------

// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder with enable and out-of-range flag.
// Outputs reflect the inputs sampled at the previous rising edge of clk.
module decoder #(
    parameter int WIDTH = 8,
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] in,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             range_err
);

    // One bit wider than the select so WIDTH itself is representable (e.g. 256).
    localparam logic [SEL_W:0] LIMIT = WIDTH[SEL_W:0];

    logic [WIDTH-1:0] out_p1;
    logic             vld_p1;
    logic             err_p1;

    // Loop form keeps out-of-range selects (non-power-of-two WIDTH) all-zero.
    function automatic logic [WIDTH-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [WIDTH-1:0] oh;
        oh = '0;
        for (int i = 0; i < WIDTH; i++) begin
            oh[i] = (sel == i[SEL_W-1:0]);
        end
        return oh;
    endfunction

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return ({1'b0, sel} < LIMIT);
    endfunction

    // Stage p0 -> p1: enable is tested before the select so an unknown select
    // while disabled never reaches the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (!enable) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else if (in_range(in)) begin
            out_p1 <= onehot(in);
            vld_p1 <= 1'b1;
            err_p1 <= 1'b0;
        end else begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b1;
        end
    end

    assign out       = out_p1;
    assign valid     = vld_p1;
    assign range_err = err_p1;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: an 8-line and a 5-line instance, a per-cycle model
// compare on the falling edge, and directed literal checks after each edge.
module tb_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in8, in5;
    logic       en8, en5;
    logic [7:0] out8;
    logic [4:0] out5;
    logic       valid8, valid5, err8, err5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in(in8), .enable(en8),
        .out(out8), .valid(valid8), .range_err(err8)
    );

    decoder #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .in(in5), .enable(en5),
        .out(out5), .valid(valid5), .range_err(err5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: inputs captured at each edge, outputs predicted from the rules.
    logic       armed = 1'b0;
    logic       rst_c, en8_c, en5_c;
    logic [2:0] in8_c, in5_c;

    always @(posedge clk) begin
        rst_c <= rst;
        en8_c <= en8;
        en5_c <= en5;
        in8_c <= in8;
        in5_c <= in5;
        if (rst) armed <= 1'b1;
    end

    function automatic int model_out(input logic r, input logic e, input logic [2:0] s, input int w);
        if (r || !e) return 0;
        if (int'(s) < w) return 1 << s;
        return 0;
    endfunction

    function automatic logic model_err(input logic r, input logic e, input logic [2:0] s, input int w);
        return !r && e && (int'(s) >= w);
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            int e8, e5;
            e8 = model_out(rst_c, en8_c, in8_c, 8);
            e5 = model_out(rst_c, en5_c, in5_c, 5);
            check("model out8", {24'd0, out8}, e8);
            check("model valid8", {31'd0, valid8}, {31'd0, e8 != 0});
            check("model err8", {31'd0, err8}, {31'd0, model_err(rst_c, en8_c, in8_c, 8)});
            check("onehot8", {31'd0, $countones(out8) <= 1}, 32'd1);
            check("model out5", {27'd0, out5}, e5);
            check("model valid5", {31'd0, valid5}, {31'd0, e5 != 0});
            check("model err5", {31'd0, err5}, {31'd0, model_err(rst_c, en5_c, in5_c, 5)});
        end
    end

    // Apply inputs, let one edge pass, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic r, input logic e, input logic [2:0] s);
        #1;
        rst = r;
        en8 = e;
        in8 = s;
        step();
    endtask

    initial begin
        rst = 1'b1; en8 = 1'b1; in8 = 3'd5; en5 = 1'b0; in5 = 3'd0;

        // Reset held two edges with enable=1, in=5.
        step();
        check("reset out c1", {24'd0, out8}, 32'h00);
        check("reset valid c1", {31'd0, valid8}, 32'd0);
        check("reset err c1", {31'd0, err8}, 32'd0);
        step();
        check("reset out c2", {24'd0, out8}, 32'h00);
        check("reset valid c2", {31'd0, valid8}, 32'd0);
        drive8(1'b0, 1'b1, 3'd5);
        check("first after reset", {24'd0, out8}, 32'h20);
        check("first valid", {31'd0, valid8}, 32'd1);

        // Disable then enable.
        drive8(1'b0, 1'b0, 3'd3);
        check("disabled out", {24'd0, out8}, 32'h00);
        check("disabled valid", {31'd0, valid8}, 32'd0);
        drive8(1'b0, 1'b1, 3'd3);
        check("enable in3", {24'd0, out8}, 32'h08);
        check("enable valid", {31'd0, valid8}, 32'd1);

        // Boundaries.
        drive8(1'b0, 1'b1, 3'd7);
        check("boundary 7", {24'd0, out8}, 32'h80);
        drive8(1'b0, 1'b1, 3'd0);
        check("boundary 0", {24'd0, out8}, 32'h01);

        // Sweep.
        for (int i = 0; i < 8; i++) begin
            drive8(1'b0, 1'b1, 3'(i));
            check("sweep out", {24'd0, out8}, 32'd1 << i);
            check("sweep valid", {31'd0, valid8}, 32'd1);
        end

        // Mid-stream reset at in=4.
        for (int i = 0; i < 8; i++) begin
            drive8(i == 4, 1'b1, 3'(i));
            if (i == 4) check("midreset out", {24'd0, out8}, 32'h00);
            else        check("midreset sweep", {24'd0, out8}, 32'd1 << i);
        end

        // Unknown select while disabled.
        drive8(1'b0, 1'b0, 3'bxxx);
        check("x disabled out", {24'd0, out8}, 32'h00);
        check("x disabled valid", {31'd0, valid8}, 32'd0);
        check("x disabled err", {31'd0, err8}, 32'd0);

        // Out-of-range on the 5-line instance.
        #1; en8 = 1'b0; in8 = 3'd0;
        en5 = 1'b1; in5 = 3'd4;
        step();
        check("w5 in4 out", {27'd0, out5}, 32'h10);
        check("w5 in4 err", {31'd0, err5}, 32'd0);
        #1; in5 = 3'd6;
        step();
        check("w5 in6 out", {27'd0, out5}, 32'h00);
        check("w5 in6 valid", {31'd0, valid5}, 32'd0);
        check("w5 in6 err", {31'd0, err5}, 32'd1);
        #1; in5 = 3'd5;
        step();
        check("w5 in5 err", {31'd0, err5}, 32'd1);
        #1; in5 = 3'd0;
        step();
        check("w5 in0 out", {27'd0, out5}, 32'h01);
        check("w5 in0 err", {31'd0, err5}, 32'd0);
        #1; en5 = 1'b0; in5 = 3'd7;
        step();
        check("w5 disabled err", {31'd0, err5}, 32'd0);
        #1; en5 = 1'b1; in5 = 3'd7;
        step();
        check("w5 in7 err", {31'd0, err5}, 32'd1);
        #1; rst = 1'b1;
        step();
        check("w5 reset err", {31'd0, err5}, 32'd0);
        #1; rst = 1'b0; en5 = 1'b0;
        step();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
